// File: rtl/inpkt_checksum_check_pkg.sv
// Shared definitions for the host packet checksum receive path: header layout,
// word/sum widths, FSM state encoding and the length-field validity rule.
`ifndef MSB
`define MSB(w) ((w) - 1)
`endif

package inpkt_checksum_check_pkg;

  localparam int unsigned WORD_W         = 16;
  localparam int unsigned SUM_W          = 32;
  localparam int unsigned PKT_HEADER_LEN = 10;
  localparam int unsigned HDR_WORDS      = PKT_HEADER_LEN / 2;
  localparam int unsigned LEN_LO         = 3;
  localparam int unsigned LEN_HI         = 4;
  localparam int unsigned LEN_W          = 24;

  typedef enum logic [2:0] {
    ST_HDR,
    ST_HCS0,
    ST_HCS1,
    ST_HOUT,
    ST_DATA,
    ST_DCS0,
    ST_DCS1,
    ST_ERROR
  } state_t;

  // Data is carried as whole 16-bit words, so the byte length must be even and non-zero.
  function automatic logic len_invalid(input logic [LEN_W-1:0] len,
                                       input logic [LEN_W-1:0] max_len);
    return (len == '0) || len[0] || (len > max_len);
  endfunction

endpackage

// File: rtl/inpkt_checksum_check_pkt_checksum32.sv
// 32-bit packet checksum accumulator: words are paired low-then-high into 32-bit
// addends; a trailing unpaired word is folded into sum_final combinationally.
module pkt_checksum32
  import inpkt_checksum_check_pkg::*;
(
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_clear,
  input  logic                   i_add,
  input  logic [`MSB(WORD_W):0]  i_word,
  output logic [`MSB(SUM_W):0]   o_sum_final
);

  logic [SUM_W-1:0]  r_sum;
  logic [WORD_W-1:0] r_tmp;
  logic              r_pending;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sum     <= '0;
      r_tmp     <= '0;
      r_pending <= 1'b0;
    end else if (i_clear) begin
      r_sum     <= '0;
      r_tmp     <= '0;
      r_pending <= 1'b0;
    end else if (i_add) begin
      if (r_pending) begin
        r_sum     <= r_sum + {i_word, r_tmp};
        r_pending <= 1'b0;
      end else begin
        r_tmp     <= i_word;
        r_pending <= 1'b1;
      end
    end
  end

  assign o_sum_final = r_sum + (r_pending ? {{(SUM_W - WORD_W){1'b0}}, r_tmp} : '0);

endmodule

// File: rtl/inpkt_checksum_check.sv
// Receive-side packet checksum checker: buffers and verifies the header, streams
// data with framing flags, strips both checksums and latches sticky error flags.
module inpkt_checksum_check
  import inpkt_checksum_check_pkg::*;
#(
  parameter int unsigned PKT_MAX_LEN = 16384
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [`MSB(WORD_W):0] din,
  input  logic                  wr_en,
  output logic                  full,
  output logic [`MSB(WORD_W):0] dout,
  output logic                  pkt_new_out,
  output logic                  pkt_end_out,
  input  logic                  rd_en,
  output logic                  empty,
  output logic                  err_checksum,
  output logic                  err_pkt_len
);

  localparam int unsigned IDX_W = $clog2(HDR_WORDS);
  localparam int unsigned CNT_W = $clog2(PKT_MAX_LEN / 2 + 1);

  state_t            r_state;
  state_t            w_state_nx;

  logic              r_full;
  logic [WORD_W-1:0] r_din;

  logic              r_out_valid;
  logic [WORD_W-1:0] r_dout;
  logic              r_new;
  logic              r_end;

  logic [WORD_W-1:0] r_hdr [HDR_WORDS];
  logic [IDX_W-1:0]  r_idx;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_err_cs;
  logic              r_err_len;

  logic              w_consume;
  logic              w_out_free;
  logic              w_out_load;
  logic [WORD_W-1:0] w_out_data;
  logic              w_out_new;
  logic              w_out_end;
  logic              w_sum_add;
  logic              w_sum_clear;
  logic              w_hdr_wr;
  logic              w_idx_inc;
  logic              w_idx_clr;
  logic              w_cnt_load;
  logic              w_cnt_dec;
  logic              w_set_err_cs;
  logic              w_set_err_len;

  logic [SUM_W-1:0]  w_sum;
  logic [SUM_W-1:0]  w_sum_n;
  logic [LEN_W-1:0]  w_len;
  logic              w_len_bad;
  logic              w_last_hdr;
  logic              w_unused_len_pad;

  pkt_checksum32 u_csum (
    .i_clk       (CLK),
    .i_rst       (RST),
    .i_clear     (w_sum_clear),
    .i_add       (w_sum_add),
    .i_word      (r_din),
    .o_sum_final (w_sum)
  );

  assign w_sum_n          = ~w_sum;
  assign w_len            = {r_hdr[LEN_HI][7:0], r_hdr[LEN_LO]};
  assign w_len_bad        = len_invalid(w_len, LEN_W'(PKT_MAX_LEN));
  assign w_unused_len_pad = ^r_hdr[LEN_HI][WORD_W-1:8];
  assign w_last_hdr       = (r_idx == IDX_W'(HDR_WORDS - 1));
  assign w_out_free       = ~r_out_valid | rd_en;

  assign full         = r_full;
  assign empty        = ~r_out_valid;
  assign dout         = r_dout;
  assign pkt_new_out  = r_new;
  assign pkt_end_out  = r_end;
  assign err_checksum = r_err_cs;
  assign err_pkt_len  = r_err_len;

  always_comb begin
    w_state_nx    = r_state;
    w_consume     = 1'b0;
    w_out_load    = 1'b0;
    w_out_data    = r_din;
    w_out_new     = 1'b0;
    w_out_end     = 1'b0;
    w_sum_add     = 1'b0;
    w_sum_clear   = 1'b0;
    w_hdr_wr      = 1'b0;
    w_idx_inc     = 1'b0;
    w_idx_clr     = 1'b0;
    w_cnt_load    = 1'b0;
    w_cnt_dec     = 1'b0;
    w_set_err_cs  = 1'b0;
    w_set_err_len = 1'b0;

    unique case (r_state)
      ST_HDR: begin
        if (r_full) begin
          w_consume = 1'b1;
          w_sum_add = 1'b1;
          w_hdr_wr  = 1'b1;
          if (w_last_hdr) begin
            w_idx_clr  = 1'b1;
            w_state_nx = ST_HCS0;
          end else begin
            w_idx_inc = 1'b1;
          end
        end
      end
      ST_HCS0: begin
        if (r_full) begin
          w_consume = 1'b1;
          if (r_din != w_sum_n[WORD_W-1:0]) begin
            w_set_err_cs = 1'b1;
            w_state_nx   = ST_ERROR;
          end else begin
            w_state_nx = ST_HCS1;
          end
        end
      end
      ST_HCS1: begin
        if (r_full) begin
          w_consume = 1'b1;
          if (r_din != w_sum_n[SUM_W-1:WORD_W]) begin
            w_set_err_cs = 1'b1;
            w_state_nx   = ST_ERROR;
          end else if (w_len_bad) begin
            w_set_err_len = 1'b1;
            w_state_nx    = ST_ERROR;
          end else begin
            w_state_nx = ST_HOUT;
          end
        end
      end
      // Input is held off here so the header buffer can be replayed without a second copy.
      ST_HOUT: begin
        if (w_out_free) begin
          w_out_load = 1'b1;
          w_out_data = r_hdr[r_idx];
          w_out_new  = (r_idx == '0);
          if (w_last_hdr) begin
            w_idx_clr   = 1'b1;
            w_sum_clear = 1'b1;
            w_cnt_load  = 1'b1;
            w_state_nx  = ST_DATA;
          end else begin
            w_idx_inc = 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (r_full && w_out_free) begin
          w_consume  = 1'b1;
          w_out_load = 1'b1;
          w_out_data = r_din;
          w_sum_add  = 1'b1;
          if (r_cnt == CNT_W'(1)) begin
            w_out_end  = 1'b1;
            w_state_nx = ST_DCS0;
          end else begin
            w_cnt_dec = 1'b1;
          end
        end
      end
      ST_DCS0: begin
        if (r_full) begin
          w_consume = 1'b1;
          if (r_din != w_sum_n[WORD_W-1:0]) begin
            w_set_err_cs = 1'b1;
            w_state_nx   = ST_ERROR;
          end else begin
            w_state_nx = ST_DCS1;
          end
        end
      end
      ST_DCS1: begin
        if (r_full) begin
          w_consume = 1'b1;
          if (r_din != w_sum_n[SUM_W-1:WORD_W]) begin
            w_set_err_cs = 1'b1;
            w_state_nx   = ST_ERROR;
          end else begin
            w_sum_clear = 1'b1;
            w_state_nx  = ST_HDR;
          end
        end
      end
      ST_ERROR: begin
        w_consume = r_full;
      end
      default: begin
        w_state_nx = ST_ERROR;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_full <= 1'b0;
      r_din  <= '0;
    end else if (wr_en && (!r_full || w_consume)) begin
      r_full <= 1'b1;
      r_din  <= din;
    end else if (w_consume) begin
      r_full <= 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_out_valid <= 1'b0;
      r_dout      <= '0;
      r_new       <= 1'b0;
      r_end       <= 1'b0;
    end else if (w_out_load) begin
      r_out_valid <= 1'b1;
      r_dout      <= w_out_data;
      r_new       <= w_out_new;
      r_end       <= w_out_end;
    end else if (rd_en) begin
      r_out_valid <= 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state   <= ST_HDR;
      r_idx     <= '0;
      r_cnt     <= '0;
      r_err_cs  <= 1'b0;
      r_err_len <= 1'b0;
      for (int unsigned i = 0; i < HDR_WORDS; i++) begin
        r_hdr[i] <= '0;
      end
    end else begin
      r_state <= w_state_nx;
      if (w_hdr_wr) begin
        r_hdr[r_idx] <= r_din;
      end
      if (w_idx_clr) begin
        r_idx <= '0;
      end else if (w_idx_inc) begin
        r_idx <= r_idx + 1'b1;
      end
      if (w_cnt_load) begin
        r_cnt <= w_len[CNT_W:1];
      end else if (w_cnt_dec) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (w_set_err_cs) begin
        r_err_cs <= 1'b1;
      end
      if (w_set_err_len) begin
        r_err_len <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_inpkt_checksum_check.sv
// Directed + randomized bench for inpkt_checksum_check; expected output stream and
// error flags come from a packet-level reference model over the input word list.
module tb_inpkt_checksum_check;

  localparam int unsigned MAX_LEN = 16384;

  logic        CLK = 1'b0;
  logic        RST;
  logic [15:0] din;
  logic        wr_en;
  logic        full;
  logic [15:0] dout;
  logic        pkt_new_out;
  logic        pkt_end_out;
  logic        rd_en;
  logic        empty;
  logic        err_checksum;
  logic        err_pkt_len;

  always #5 CLK = ~CLK;

  inpkt_checksum_check #(.PKT_MAX_LEN(MAX_LEN)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .din          (din),
    .wr_en        (wr_en),
    .full         (full),
    .dout         (dout),
    .pkt_new_out  (pkt_new_out),
    .pkt_end_out  (pkt_end_out),
    .rd_en        (rd_en),
    .empty        (empty),
    .err_checksum (err_checksum),
    .err_pkt_len  (err_pkt_len)
  );

  int          checks   = 0;
  int          failures = 0;
  logic [15:0] in_q [$];
  logic [15:0] sec_q [$];
  logic [17:0] exp_q [$];
  logic [17:0] got_q [$];
  int          got_cyc [$];
  logic        exp_cs;
  logic        exp_len;
  logic [15:0] spec_words [7];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] csum(input logic [15:0] w [$]);
    logic [31:0] s;
    s = '0;
    for (int i = 0; i < w.size(); i += 2) begin
      if (i + 1 < w.size()) s = s + {w[i+1], w[i]};
      else                  s = s + {16'h0000, w[i]};
    end
    return s;
  endfunction

  // Appends a section followed by its two checksum words, optionally corrupted by flip.
  task automatic push_section(input logic [15:0] w [$], input logic [31:0] flip);
    logic [31:0] c;
    c = ~csum(w) ^ flip;
    foreach (w[i]) in_q.push_back(w[i]);
    in_q.push_back(c[15:0]);
    in_q.push_back(c[31:16]);
  endtask

  task automatic push_pkt(input logic [23:0] len, input int ndw,
                          input logic [31:0] hflip, input logic [31:0] dflip);
    logic [15:0] h [$];
    logic [15:0] d [$];
    for (int i = 0; i < 3; i++) h.push_back(16'($urandom));
    h.push_back(len[15:0]);
    h.push_back({8'h00, len[23:16]});
    push_section(h, hflip);
    for (int i = 0; i < ndw; i++) d.push_back(16'($urandom));
    push_section(d, dflip);
  endtask

  // Walks in_q packet by packet; stops at the first error or where the stream runs out.
  task automatic model();
    int          pos;
    int          sz;
    int          n;
    logic [15:0] sec [$];
    logic [31:0] got;
    logic [23:0] len;
    pos = 0;
    sz  = in_q.size();
    exp_q.delete();
    exp_cs  = 1'b0;
    exp_len = 1'b0;
    while (pos + 7 <= sz) begin
      sec.delete();
      for (int i = 0; i < 5; i++) sec.push_back(in_q[pos+i]);
      got = {in_q[pos+6], in_q[pos+5]};
      if (got != ~csum(sec)) begin exp_cs = 1'b1; break; end
      len = {sec[4][7:0], sec[3]};
      if (len == 24'd0 || len[0] || len > 24'(MAX_LEN)) begin exp_len = 1'b1; break; end
      n = int'(len) / 2;
      for (int i = 0; i < 5; i++) exp_q.push_back({1'(i == 0), 1'b0, sec[i]});
      pos += 7;
      sec.delete();
      for (int k = 0; k < n && pos + k < sz; k++) begin
        sec.push_back(in_q[pos+k]);
        exp_q.push_back({1'b0, 1'(k == n - 1), in_q[pos+k]});
      end
      if (pos + n + 2 > sz) break;
      got = {in_q[pos+n+1], in_q[pos+n]};
      if (got != ~csum(sec)) begin exp_cs = 1'b1; break; end
      pos += n + 2;
    end
  endtask

  // rdm: 0 always read, 1 read one clock in three, 2 random read.
  // wrm: 0 write whenever not full, 1 random, 2 write every clock once nfast words are out.
  task automatic run_stream(input int rdm, input int wrm, input int nfast, input string tag);
    int   wi;
    int   cyc;
    int   idle;
    int   budget;
    logic rd;
    logic wr;
    wi     = 0;
    cyc    = 0;
    idle   = 0;
    budget = in_q.size() * 8 + 300;
    model();
    got_q.delete();
    got_cyc.delete();
    while (cyc < budget && idle < 30) begin
      @(negedge CLK);
      case (rdm)
        0:       rd = 1'b1;
        1:       rd = (cyc % 3 == 0);
        default: rd = ($urandom_range(0, 1) == 1);
      endcase
      rd_en = rd;
      if (rd && !empty) begin
        got_q.push_back({pkt_new_out, pkt_end_out, dout});
        got_cyc.push_back(cyc);
      end
      if (wi >= in_q.size())                 wr = 1'b0;
      else if (wrm == 2 && got_q.size() >= nfast) wr = 1'b1;
      else if (wrm == 1)                     wr = !full && ($urandom_range(0, 1) == 1);
      else                                   wr = !full;
      wr_en = wr;
      din   = wr ? in_q[wi] : 16'($urandom);
      if (wr) wi++;
      cyc++;
      if (wi >= in_q.size() && got_q.size() >= exp_q.size()) idle++;
    end
    @(negedge CLK);
    wr_en = 1'b0;
    rd_en = 1'b0;
    check({tag, "_done"}, 32'(idle >= 30), 32'd1);
    check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check($sformatf("%s_w%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    check({tag, "_errcs"}, 32'(err_checksum), 32'(exp_cs));
    check({tag, "_errlen"}, 32'(err_pkt_len), 32'(exp_len));
    check({tag, "_full"}, 32'(full), 32'd0);
    check({tag, "_empty"}, 32'(empty), 32'd1);
  endtask

  task automatic do_reset();
    wr_en = 1'b0;
    rd_en = 1'b0;
    RST   = 1'b1;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    in_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_full"}, 32'(full), 32'd0);
    check({tag, "_empty"}, 32'(empty), 32'd1);
    check({tag, "_dout"}, 32'(dout), 32'd0);
    check({tag, "_new"}, 32'(pkt_new_out), 32'd0);
    check({tag, "_end"}, 32'(pkt_end_out), 32'd0);
    check({tag, "_errcs"}, 32'(err_checksum), 32'd0);
    check({tag, "_errlen"}, 32'(err_pkt_len), 32'd0);
  endtask

  task automatic push_spec_pkt(input logic [15:0] len_lo, input logic [31:0] hflip,
                               input logic [31:0] dflip);
    sec_q.delete();
    sec_q.push_back(16'h0101); sec_q.push_back(16'h0000); sec_q.push_back(16'h0007);
    sec_q.push_back(len_lo);   sec_q.push_back(16'h0000);
    push_section(sec_q, hflip);
    sec_q.delete();
    sec_q.push_back(16'h1234); sec_q.push_back(16'h5678);
    push_section(sec_q, dflip);
  endtask

  initial begin
    spec_words[0] = 16'h0101; spec_words[1] = 16'h0000; spec_words[2] = 16'h0007;
    spec_words[3] = 16'h0004; spec_words[4] = 16'h0000; spec_words[5] = 16'h1234;
    spec_words[6] = 16'h5678;
    din   = '0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    RST   = 1'b1;
    repeat (3) @(negedge CLK);
    check_reset_outputs("rst_hold");
    do_reset();
    check_reset_outputs("rst_init");

    // Reference good packet: header/data checksum words FEF7,FFFB / EDCB,A987.
    push_spec_pkt(16'h0004, 32'h0, 32'h0);
    run_stream(0, 0, 0, "good");
    for (int i = 0; i < 7 && i < got_q.size(); i++)
      check($sformatf("spec_dout%0d", i), 32'(got_q[i][15:0]), 32'(spec_words[i]));

    // Data checksum high word A987 -> A986; the following packet must be discarded.
    do_reset();
    push_spec_pkt(16'h0004, 32'h0, 32'h0001_0000);
    push_pkt(24'd8, 4, 32'h0, 32'h0);
    run_stream(0, 0, 0, "baddcs");

    // Header checksum FEF7 -> FEF6.
    do_reset();
    push_spec_pkt(16'h0004, 32'h0000_0001, 32'h0);
    push_pkt(24'd8, 4, 32'h0, 32'h0);
    run_stream(2, 1, 0, "badhcs");

    do_reset();
    push_spec_pkt(16'h0003, 32'h0, 32'h0);
    run_stream(0, 0, 0, "oddlen");

    do_reset();
    for (int p = 0; p < 3; p++) begin
      int nw;
      nw = int'($urandom_range(1, 32));
      push_pkt(24'(2 * nw), nw, 32'h0, 32'h0);
    end
    run_stream(1, 1, 0, "rand3");

    do_reset();
    push_pkt(24'(MAX_LEN), int'(MAX_LEN / 2), 32'h0, 32'h0);
    run_stream(2, 1, 0, "maxlen");

    do_reset();
    push_pkt(24'(MAX_LEN + 2), 4, 32'h0, 32'h0);
    run_stream(0, 0, 0, "overlen");

    do_reset();
    push_pkt(24'd0, 2, 32'h0, 32'h0);
    run_stream(0, 0, 0, "zerolen");

    do_reset();
    push_pkt(24'h01_0002, 2, 32'h0, 32'h0);
    run_stream(0, 0, 0, "hilen");

    // Back-to-back data at full rate: input written every clock while the register is full.
    do_reset();
    push_pkt(24'd40, 20, 32'h0, 32'h0);
    run_stream(0, 2, 5, "tput");
    if (got_cyc.size() == 25)
      check("tput_span", 32'(got_cyc[24] - got_cyc[5]), 32'd19);
    else
      check("tput_len", 32'(got_cyc.size()), 32'd25);

    // Two packets, then a third cut off after three data words by an asynchronous reset.
    do_reset();
    push_pkt(24'd6, 3, 32'h0, 32'h0);
    push_pkt(24'd10, 5, 32'h0, 32'h0);
    sec_q.delete();
    for (int i = 0; i < 3; i++) sec_q.push_back(16'($urandom));
    sec_q.push_back(16'd16);
    sec_q.push_back(16'h0000);
    push_section(sec_q, 32'h0);
    for (int i = 0; i < 3; i++) in_q.push_back(16'($urandom));
    run_stream(2, 1, 0, "trunc");
    @(posedge CLK);
    #2 RST = 1'b1;
    #1 check_reset_outputs("rst_async");
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    in_q.delete();
    push_pkt(24'd12, 6, 32'h0, 32'h0);
    run_stream(0, 1, 0, "after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
